// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the parametrised multi-cycle CPU core:
//   - 16-bit instruction field positions
//   - 4-bit opcode enum (opcode 0 is MUL when CPU_MUL_EN is defined, else NOP)
//   - FSM state enum
//   - ALU operation select and the per-opcode decode helper
// Optional feature macro: CPU_MUL_EN
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int INSTR_W  = 16;
  localparam int MAX_REGS = 8;   // 3-bit register fields address at most 8 GPRs

  // Instruction field bit positions: op[15:12] rd[11:9] rs1[8:6] rs2[5:3] imm[7:0]
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
`ifdef CPU_MUL_EN
    OP_MUL = 4'h0,
`else
    OP_NOP = 4'h0,
`endif
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_NOT = 4'h6,
    OP_SHL = 4'h7,
    OP_SHR = 4'h8,
    OP_LDI = 4'h9,
    OP_MOV = 4'hA,
    OP_JMP = 4'hB,
    OP_BZ  = 4'hC,
    OP_BC  = 4'hD,
    OP_CMP = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOT,
    ALU_SHL,
    ALU_SHR,
    ALU_PASS_A,
    ALU_PASS_B,
    ALU_MUL
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    wr_gpr;     // instruction ends with a GPR writeback
    logic    upd_flags;  // instruction updates Z/C
  } decode_t;

  // Per-opcode control. Branches, NOP and HLT keep the defaults; the core
  // handles their pc/state effects directly.
  function automatic decode_t decode_op(opcode_e op);
    decode_t d;
    d = '{alu_op: ALU_PASS_A, wr_gpr: 1'b0, upd_flags: 1'b0};
    case (op)
      OP_ADD: d = '{alu_op: ALU_ADD,    wr_gpr: 1'b1, upd_flags: 1'b1};
      OP_SUB: d = '{alu_op: ALU_SUB,    wr_gpr: 1'b1, upd_flags: 1'b1};
      OP_AND: d = '{alu_op: ALU_AND,    wr_gpr: 1'b1, upd_flags: 1'b1};
      OP_OR:  d = '{alu_op: ALU_OR,     wr_gpr: 1'b1, upd_flags: 1'b1};
      OP_XOR: d = '{alu_op: ALU_XOR,    wr_gpr: 1'b1, upd_flags: 1'b1};
      OP_NOT: d = '{alu_op: ALU_NOT,    wr_gpr: 1'b1, upd_flags: 1'b1};
      OP_SHL: d = '{alu_op: ALU_SHL,    wr_gpr: 1'b1, upd_flags: 1'b1};
      OP_SHR: d = '{alu_op: ALU_SHR,    wr_gpr: 1'b1, upd_flags: 1'b1};
      OP_LDI: d = '{alu_op: ALU_PASS_B, wr_gpr: 1'b1, upd_flags: 1'b0};
      OP_MOV: d = '{alu_op: ALU_PASS_A, wr_gpr: 1'b1, upd_flags: 1'b0};
      OP_CMP: d = '{alu_op: ALU_SUB,    wr_gpr: 1'b0, upd_flags: 1'b1};
`ifdef CPU_MUL_EN
      OP_MUL: d = '{alu_op: ALU_MUL,    wr_gpr: 1'b1, upd_flags: 1'b1};
`endif
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// -----------------------------------------------------------------------------
// cpu_alu
// Combinational ALU for cpu_core_param. All arithmetic is modulo 2^DATA_W.
// Ports:
//   a_i, b_i  [DATA_W]  operands (b_i carries the zero-extended immediate for LDI)
//   op_i      alu_op_e  operation select
//   result_o  [DATA_W]  result
//   z_o       1         result == 0
//   c_o       1         carry (ADD), borrow (SUB), bit shifted out (SHL/SHR),
//                       high half non-zero (MUL); 0 for logic ops
// Optional feature macro: CPU_MUL_EN (adds the DATA_W x DATA_W multiplier)
// -----------------------------------------------------------------------------
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              z_o,
  output logic              c_o
);

`ifdef CPU_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
`endif

  always_comb begin
    // NOTE: every output gets a default before the case, so no op leaves a
    // value unassigned and no latch is inferred.
    result_o = '0;
    c_o      = 1'b0;
    case (op_i)
      ALU_ADD:    {c_o, result_o} = {1'b0, a_i} + {1'b0, b_i};
      ALU_SUB: begin
        result_o = a_i - b_i;
        c_o      = (a_i < b_i);
      end
      ALU_AND:    result_o = a_i & b_i;
      ALU_OR:     result_o = a_i | b_i;
      ALU_XOR:    result_o = a_i ^ b_i;
      ALU_NOT:    result_o = ~a_i;
      ALU_SHL:    {c_o, result_o} = {a_i, 1'b0};
      ALU_SHR:    {result_o, c_o} = {1'b0, a_i};
      ALU_PASS_A: result_o = a_i;
      ALU_PASS_B: result_o = b_i;
`ifdef CPU_MUL_EN
      ALU_MUL: begin
        result_o = prod[DATA_W-1:0];
        c_o      = |prod[2*DATA_W-1:DATA_W];
      end
`endif
      default: ;
    endcase
    z_o = (result_o == '0);
  end

endmodule

// File: rtl/cpu_core_param.sv
// -----------------------------------------------------------------------------
// cpu_core_param
// Parametrised multi-cycle CPU core: IDLE -> FETCH -> DECODE -> EXEC [-> WB]
// with a HALT state and restart. Instructions arrive over a req/valid fetch port.
// Ports:
//   clk, rst (async, active-low)
//   run                      start pulse, honoured in IDLE/HALT
//   ld_en, ld_addr, ld_data  GPR preload, honoured in IDLE/HALT
//   imem_req, imem_addr      fetch request held until imem_valid; address = pc
//   imem_rdata, imem_valid   instruction word, sampled only in FETCH
//   wb_en, wb_addr, wb_data  one-cycle pulse per instruction GPR write
//   flag_z, flag_c           zero / carry-borrow flags
//   busy                     FETCH/DECODE/EXEC/WB
//   halted                   HALT
// Parameters: DATA_W (8..32), NREGS (2/4/8), PC_W (4..16)
// Optional feature macro: CPU_MUL_EN (opcode 0 becomes MUL instead of NOP)
// -----------------------------------------------------------------------------
module cpu_core_param
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int PC_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               ld_en,
  input  logic [2:0]         ld_addr,
  input  logic [DATA_W-1:0]  ld_data,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic               wb_en,
  output logic [2:0]         wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               flag_z,
  output logic               flag_c,
  output logic               busy,
  output logic               halted
);

  // Register fields keep only their low $clog2(NREGS) bits. The array is sized
  // for the full 3-bit field so masked indices match its width exactly; entries
  // at or above NREGS are never written and stay constant zero.
  localparam logic [2:0] IDX_MASK = 3'(NREGS - 1);

  state_e              state_q;
  logic [PC_W-1:0]     pc_q;
  logic [INSTR_W-1:0]  ir_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                z_q, c_q;
  logic [DATA_W-1:0]   gpr_q [MAX_REGS];
  logic                wb_en_q;
  logic [2:0]          wb_addr_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic                imem_req_q, busy_q, halted_q;

  opcode_e             op;
  decode_t             dec;
  logic [2:0]          rd_f, rs1_f, rs2_f, ld_f;
  logic [7:0]          imm;
  logic [DATA_W-1:0]   alu_b, alu_res;
  logic                alu_z, alu_c;
  logic [PC_W-1:0]     pc_inc, br_target, pc_next;

  assign op        = opcode_e'(ir_q[OP_MSB:OP_LSB]);
  assign dec       = decode_op(op);
  assign rd_f      = ir_q[RD_MSB:RD_LSB] & IDX_MASK;
  assign rs1_f     = ir_q[RS1_MSB:RS1_LSB] & IDX_MASK;
  assign rs2_f     = ir_q[RS2_MSB:RS2_LSB] & IDX_MASK;
  assign ld_f      = ld_addr & IDX_MASK;
  assign imm       = ir_q[IMM_MSB:IMM_LSB];
  assign alu_b     = (op == OP_LDI) ? DATA_W'(imm) : b_q;
  assign pc_inc    = pc_q + PC_W'(1);
  assign br_target = PC_W'(imm);

  // Branches test the flags left by earlier instructions; they never update them.
  always_comb begin
    pc_next = pc_inc;
    case (op)
      OP_JMP:  pc_next = br_target;
      OP_BZ:   if (z_q) pc_next = br_target;
      OP_BC:   if (c_q) pc_next = br_target;
      default: ;
    endcase
  end

  cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i      (a_q),
    .b_i      (alu_b),
    .op_i     (dec.alu_op),
    .result_o (alu_res),
    .z_o      (alu_z),
    .c_o      (alu_c)
  );

  // NOTE: all sequential state uses non-blocking assignments so every register
  // in this block samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      wb_en_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      imem_req_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      // NOTE: the GPRs are plain flops rather than a RAM, so they take the
      // async reset like any other architectural state.
      for (int i = 0; i < MAX_REGS; i++) gpr_q[i] <= '0;
    end else begin
      wb_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HALT: begin
          if (ld_en) gpr_q[ld_f] <= ld_data;
          if (run) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;      // IDLE is only reached via reset, so pc is 0 there too
            imem_req_q <= 1'b1;
            busy_q     <= 1'b1;
            halted_q   <= 1'b0;
          end
        end
        S_FETCH: begin
          if (imem_valid) begin
            ir_q       <= imem_rdata;
            imem_req_q <= 1'b0;
            state_q    <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q     <= gpr_q[rs1_f];
          b_q     <= gpr_q[rs2_f];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (dec.upd_flags) begin
            z_q <= alu_z;
            c_q <= alu_c;
          end
          if (op == OP_HLT) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else if (dec.wr_gpr) begin
            wb_en_q   <= 1'b1;
            wb_addr_q <= rd_f;
            wb_data_q <= alu_res;
            state_q   <= S_WB;
          end else begin
            pc_q       <= pc_next;
            imem_req_q <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        S_WB: begin
          gpr_q[wb_addr_q] <= wb_data_q;
          pc_q             <= pc_inc;
          imem_req_q       <= 1'b1;
          state_q          <= S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_core_param.sv
// -----------------------------------------------------------------------------
// tb_cpu_core_param
// Self-checking bench for cpu_core_param. Each instruction is served on the
// fetch port by the bench; an arithmetic reference model tracks GPRs, flags,
// pc and halt state and predicts writeback, flags, next fetch address and
// cycle count. Honours CPU_MUL_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_cpu_core_param;

  localparam int DATA_W = 8;
  localparam int NREGS  = 4;
  localparam int PC_W   = 8;
  localparam longint unsigned DMOD = 64'd1 << DATA_W;
  localparam longint unsigned PMOD = 64'd1 << PC_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              run = 1'b0;
  logic              ld_en = 1'b0;
  logic [2:0]        ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [15:0]       imem_rdata = '0;
  logic              imem_valid = 1'b0;
  logic              wb_en;
  logic [2:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flag_z, flag_c, busy, halted;

  int total = 0;
  int bad   = 0;

  // Reference model state
  longint unsigned m_reg [8];
  bit              m_z, m_c, m_halt;
  longint unsigned m_pc;

  cpu_core_param #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .PC_W   (PC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at 1ms, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] ins_r(int op, int rd, int rs1, int rs2);
    return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
  endfunction

  function automatic logic [15:0] ins_i(int op, int rd, int imm);
    return {4'(op), 3'(rd), 1'b0, 8'(imm)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
    m_z = 0; m_c = 0; m_halt = 0; m_pc = 0;
  endtask

  // Architectural effect of one instruction, from the ISA rules.
  task automatic model_step(input logic [15:0] ins, output bit wr, output int waddr,
                            output longint unsigned wdata);
    int op  = int'(ins[15:12]);
    int rd  = int'(ins[11:9]) % NREGS;
    int rs1 = int'(ins[8:6]) % NREGS;
    int rs2 = int'(ins[5:3]) % NREGS;
    longint unsigned a = m_reg[rs1];
    longint unsigned b = m_reg[rs2];
    longint unsigned imm = longint'(ins[7:0]);
    longint unsigned r = 0;
    longint unsigned nxt = (m_pc + 1) % PMOD;
    bit fl = 0, cy = 0;
    wr = 0;
    case (op)
      1:  begin r = a + b; cy = (r >= DMOD); fl = 1; wr = 1; end
      2:  begin cy = (a < b); r = (a + DMOD - b); fl = 1; wr = 1; end
      3:  begin r = a & b; fl = 1; wr = 1; end
      4:  begin r = a | b; fl = 1; wr = 1; end
      5:  begin r = a ^ b; fl = 1; wr = 1; end
      6:  begin r = DMOD - 1 - a; fl = 1; wr = 1; end
      7:  begin r = a * 2; cy = (r >= DMOD); fl = 1; wr = 1; end
      8:  begin cy = (a % 2 == 1); r = a / 2; fl = 1; wr = 1; end
      9:  begin r = imm; wr = 1; end
      10: begin r = a; wr = 1; end
      11: nxt = imm % PMOD;
      12: if (m_z) nxt = imm % PMOD;
      13: if (m_c) nxt = imm % PMOD;
      14: begin cy = (a < b); r = (a + DMOD - b); fl = 1; end
`ifdef CPU_MUL_EN
      0:  begin r = a * b; cy = (r >= DMOD); fl = 1; wr = 1; end
`endif
      default: ;
    endcase
    r = r % DMOD;
    if (fl) begin m_z = (r == 0); m_c = cy; end
    if (wr) m_reg[rd] = r;
    waddr = rd;
    wdata = r;
    if (op == 15) m_halt = 1;
    else m_pc = nxt;
  endtask

  task automatic wait_fetch(input string name);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (imem_req !== 1'b1) begin
      bad++;
      $display("FAIL %s fetch_wait: imem_req=%b, required 1 within 20 cycles", name, imem_req);
    end
  endtask

  // Serve one instruction and compare everything it should do.
  // junk: 0 none, 1 imem_valid pulse during DECODE, 2 ld_en+run during EXEC.
  task automatic exec_instr(input logic [15:0] ins, input int waits, input int junk,
                            input string name);
    bit              wr;
    int              waddr;
    longint unsigned wdata;
    int              cycles = 0, nwb = 0, k = 0, req_hi, exp_cyc;
    logic [PC_W-1:0] addr0;
    wait_fetch(name);
    addr0  = imem_addr;
    req_hi = (imem_req === 1'b1) ? 1 : 0;
    total++;
    if (imem_addr !== PC_W'(m_pc)) begin
      bad++;
      $display("FAIL %s fetch_addr: got %h, required %h", name, imem_addr, PC_W'(m_pc));
    end
    model_step(ins, wr, waddr, wdata);
    exp_cyc = (wr ? 4 : 3) + waits;

    for (int w = 0; w < waits; w++) begin
      imem_valid = 1'b0;
      imem_rdata = 16'($urandom);
      @(negedge clk);
      cycles++;
      if (imem_req === 1'b1 && imem_addr === addr0) req_hi++;
    end
    imem_valid = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    cycles++;
    imem_valid = 1'b0;
    imem_rdata = 16'hB033;  // a JMP 0x33 that must never be taken if sampled late

    while (imem_req !== 1'b1 && halted !== 1'b1 && k < 12) begin
      if (wb_en === 1'b1) begin
        nwb++;
        total++;
        if (wb_addr !== 3'(waddr) || wb_data !== DATA_W'(wdata)) begin
          bad++;
          $display("FAIL %s wb: got addr=%0d data=%h, required addr=%0d data=%h",
                   name, wb_addr, wb_data, waddr, DATA_W'(wdata));
        end
      end
      if (junk == 1) imem_valid = (k == 0);
      if (junk == 2) begin
        ld_en   = (k == 1);
        run     = (k == 1);
        ld_addr = 3'($urandom);
        ld_data = DATA_W'($urandom);
      end
      @(negedge clk);
      cycles++;
      k++;
    end
    imem_valid = 1'b0;
    ld_en      = 1'b0;
    run        = 1'b0;

    total++;
    if (cycles !== exp_cyc) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, cycles, exp_cyc);
    end
    total++;
    if (nwb !== (wr ? 1 : 0)) begin
      bad++;
      $display("FAIL %s wb_count: got %0d pulses, required %0d", name, nwb, wr ? 1 : 0);
    end
    total++;
    if (req_hi !== waits + 1) begin
      bad++;
      $display("FAIL %s req_hold: imem_req/addr stable for %0d cycles, required %0d",
               name, req_hi, waits + 1);
    end
    total++;
    if (flag_z !== m_z || flag_c !== m_c) begin
      bad++;
      $display("FAIL %s flags: got z=%b c=%b, required z=%b c=%b", name, flag_z, flag_c, m_z, m_c);
    end
    total++;
    if (halted !== m_halt || busy !== !m_halt) begin
      bad++;
      $display("FAIL %s status: got halted=%b busy=%b, required halted=%b busy=%b",
               name, halted, busy, m_halt, !m_halt);
    end
  endtask

  task automatic preload(input int addr, input longint unsigned val, input bit with_run);
    ld_en   = 1'b1;
    ld_addr = 3'(addr);
    ld_data = DATA_W'(val);
    run     = with_run;
    @(negedge clk);
    ld_en = 1'b0;
    run   = 1'b0;
    m_reg[addr % NREGS] = val % DMOD;
    if (with_run) begin m_pc = 0; m_halt = 0; end
  endtask

  task automatic start_run();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    m_pc = 0;
    m_halt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({imem_req, busy, halted, wb_en, flag_z, flag_c} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got req/busy/halt/wb/z/c=%b, required 000000",
               {imem_req, busy, halted, wb_en, flag_z, flag_c});
    end
    total++;
    if (imem_addr !== '0 || wb_addr !== '0 || wb_data !== '0) begin
      bad++;
      $display("FAIL reset_data: got addr=%h wb_addr=%h wb_data=%h, required all 0",
               imem_addr, wb_addr, wb_data);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b req=%b without run, required 0 0", busy, imem_req);
    end
  endtask

  task automatic test_add();
    preload(1, 'h0F, 1'b0);
    preload(2, 'hF1, 1'b1);  // load and run in the same cycle
    exec_instr(ins_r(1, 3, 1, 2), 0, 0, "add");
    total++;
    if (flag_z !== 1'b1 || flag_c !== 1'b1) begin
      bad++;
      $display("FAIL add_flags: got z=%b c=%b, required z=1 c=1", flag_z, flag_c);
    end
  endtask

  task automatic test_wait_states();
    exec_instr(ins_i(9, 0, 'h5A), 3, 0, "ldi_wait");
    exec_instr(ins_r(10, 0, 0, 0), 1, 0, "mov_r0");
  endtask

  task automatic test_branches();
    exec_instr(ins_i(9, 1, 1), 0, 0, "ldi_r1");
    exec_instr(ins_i(9, 2, 2), 0, 0, "ldi_r2");
    exec_instr(ins_r(14, 0, 1, 1), 0, 0, "cmp_eq");
    exec_instr(ins_i(12, 0, 'h20), 0, 0, "bz_taken");
    total++;
    if (imem_addr !== PC_W'(32)) begin
      bad++;
      $display("FAIL bz_target: got %h, required 20", imem_addr);
    end
    exec_instr(ins_r(14, 0, 1, 2), 0, 0, "cmp_lt");
    total++;
    if (flag_c !== 1'b1 || flag_z !== 1'b0) begin
      bad++;
      $display("FAIL cmp_borrow: got z=%b c=%b, required z=0 c=1", flag_z, flag_c);
    end
    exec_instr(ins_i(12, 0, 'h20), 0, 0, "bz_not_taken");
    exec_instr(ins_i(13, 0, 'h44), 0, 0, "bc_taken");
  endtask

  task automatic test_wrap();
    exec_instr(ins_i(11, 0, 'hFF), 0, 0, "jmp_top");
    exec_instr(ins_r(14, 0, 0, 0), 0, 0, "cmp_at_top");
    total++;
    if (imem_addr !== '0) begin
      bad++;
      $display("FAIL pc_wrap: got %h, required 0", imem_addr);
    end
  endtask

  task automatic test_ignored();
    exec_instr(ins_r(1, 3, 1, 2), 0, 1, "valid_in_decode");
    exec_instr(ins_r(14, 0, 1, 2), 0, 2, "ld_run_in_exec");
    exec_instr(ins_r(2, 1, 2, 1), 1, 2, "ld_run_in_exec_wb");
    for (int r = 0; r < NREGS; r++) exec_instr(ins_r(10, r, r, 0), 0, 0, "gpr_intact");
  endtask

  task automatic test_halt();
    exec_instr(16'hF000, 0, 0, "hlt");
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL halt_req: got imem_req=%b, required 0", imem_req);
    end
    preload(0, 'hA5, 1'b0);  // preload is honoured in HALT
    start_run();
    for (int r = 0; r < NREGS; r++) exec_instr(ins_r(10, r, r, 0), 0, 0, "restart_gpr");
  endtask

  task automatic test_random();
    logic [15:0] ins;
    int          op;
    for (int n = 0; n < 150; n++) begin
      if (m_halt) begin
        if ($urandom_range(1) == 1) preload(int'($urandom_range(7)), longint'($urandom), 1'b1);
        else start_run();
      end
      op = int'($urandom_range(15));
      if (op == 15 && $urandom_range(3) != 0) op = 1;
      ins = 16'($urandom);
      ins[15:12] = 4'(op);
      exec_instr(ins, int'($urandom_range(2)), int'($urandom_range(2)), "random");
    end
    if (m_halt) start_run();
  endtask

  task automatic test_mul();
`ifdef CPU_MUL_EN
    exec_instr(ins_i(9, 1, 'h10), 0, 0, "mul_ldi1");
    exec_instr(ins_i(9, 2, 'h10), 0, 0, "mul_ldi2");
    exec_instr(ins_r(0, 3, 1, 2), 0, 0, "mul");
    total++;
    if (flag_c !== 1'b1 || flag_z !== 1'b1) begin
      bad++;
      $display("FAIL mul_flags: got z=%b c=%b, required z=1 c=1", flag_z, flag_c);
    end
`else
    exec_instr(16'h0000, 0, 0, "nop");
`endif
  endtask

  task automatic test_mid_reset();
    exec_instr(ins_r(14, 0, 0, 0), 0, 0, "cmp_before_rst");  // leaves Z set
    wait_fetch("mid_reset");
    rst = 1'b0;
    #1;
    total++;
    if ({imem_req, busy, wb_en, flag_z, flag_c} !== 5'b0 || imem_addr !== '0) begin
      bad++;
      $display("FAIL async_reset: got req/busy/wb/z/c=%b addr=%h, required 00000 addr=0",
               {imem_req, busy, wb_en, flag_z, flag_c}, imem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    start_run();
    for (int r = 0; r < NREGS; r++) exec_instr(ins_r(10, r, r, 0), 0, 0, "post_rst_gpr");
  endtask

  initial begin
    test_reset();
    test_add();
    test_wait_states();
    test_branches();
    test_wrap();
    test_ignored();
    test_halt();
    test_random();
    test_mul();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_core_param.md
Name: cpu_core_param

Overview:
- Parametrised multi-cycle CPU core; next generation of the mini CISC datapath.
- Register-file width and count, and PC width, are parameters.
- Instructions come over an external handshaked fetch port, with a 16-bit instruction format.
- Adds Z/C flags, conditional branches, immediate load and an explicit halt/restart FSM; sits between the system instruction memory and a debug/writeback observer.

Parameters:
- DATA_W, 8, register/ALU width (8..32)
- NREGS, 4, number of GPRs (2, 4 or 8); 3-bit register fields use their low $clog2(NREGS) bits
- PC_W, 8, program counter / fetch address width (4..16)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- run  in  1  start pulse; honoured in IDLE/HALT only
- ld_en  in  1  register preload strobe; honoured in IDLE/HALT only
- ld_addr  in  3  preload register index
- ld_data  in  DATA_W  preload value
- imem_req  out  1  fetch request, held until imem_valid
- imem_addr  out  PC_W  fetch address (= pc)
- imem_rdata  in  16  instruction word
- imem_valid  in  1  instruction valid; sampled only in FETCH
- wb_en  out  1  one-cycle pulse on every GPR write by an instruction
- wb_addr  out  3  register written
- wb_data  out  DATA_W  value written
- flag_z  out  1  zero flag
- flag_c  out  1  carry/borrow flag
- busy  out  1  high in FETCH/DECODE/EXEC/WB
- halted  out  1  high in HALT

Behaviour:
- Reset (rst=0, async): state=IDLE; pc, GPRs, IR, flags all 0; all outputs 0.
- Instruction fields: op[15:12], rd[11:9], rs1[8:6], rs2[5:3], imm[7:0].
- FSM transitions:
  - IDLE: run -> FETCH.
  - FETCH: imem_req=1; on imem_valid, latch IR -> DECODE. Wait states are unbounded.
  - DECODE: latch operand A=R[rs1], B=R[rs2] -> EXEC.
  - EXEC: compute result and flags; GPR-writing ops -> WB; otherwise pc update -> FETCH; HLT -> HALT.
  - WB: R[rd]<=result, wb_en pulse, pc<=pc+1 -> FETCH.
  - HALT: run -> FETCH with pc<=0; GPRs and flags keep their values.
- Latency with zero wait states:
  - GPR-writing op: 4 cycles.
  - NOP/CMP/JMP/BZ/BC: 3 cycles.
  - Each imem wait cycle adds 1.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR (all A op B)
  - 6 NOT A, 7 SHL A by 1, 8 SHR A by 1
  - 9 LDI rd=imm zero-extended
  - A MOV rd=A
  - B JMP imm
  - C BZ imm if Z
  - D BC imm if C
  - E CMP (SUB, flags only)
  - F HLT
- Flags, updated by ops 1-8 and E only:
  - Z = (result==0).
  - C: ADD carry-out; SUB/CMP borrow (A<B unsigned); SHL MSB out; SHR LSB out; logic ops C=0.
- Arithmetic is modulo 2^DATA_W.
- pc increments modulo 2^PC_W (wraps to 0).
- Branch target = imm truncated/zero-extended to PC_W; not-taken -> pc+1.
- Preload: ld_en in IDLE/HALT writes R[ld_addr]<=ld_data next edge, no wb_en. Ignored while busy. ld_en and run in the same cycle: the load completes, then FETCH starts.
- imem_valid outside FETCH is ignored. run while busy is ignored.
- Reset mid-instruction aborts immediately: imem_req drops asynchronously and no partial writeback occurs.

Optional Feature:
- Macro: CPU_MUL_EN.
- Defined: opcode 0 = MUL; rd = low DATA_W bits of A*B, C = (high half != 0), Z per result, 4-cycle latency.
- Undefined: opcode 0 = NOP and no multiplier is synthesised.

Decomposition:
- Package cpu_pkg: opcode enum (4-bit), FSM state enum, instruction field bit positions, ALU op select typedef.
- Sub-module cpu_alu: combinational; DATA_W parameter; inputs A, B, op; outputs result, z, c; holds MUL under CPU_MUL_EN.
- GPR file and FSM stay in cpu_core_param.

Test Plan:
- Reset/preload/ADD: preload R1=0x0F, R2=0xF1, run; program ADD R3,R1,R2 -> wb_en once, wb_addr=3, wb_data=0x00, flag_z=1, flag_c=1, 4 cycles after run accepted.
- Fetch wait states: imem_valid delayed 3 cycles on LDI R0,0x5A -> imem_req held 4 cycles, imem_addr stable, R0=0x5A, 7-cycle instruction.
- Branches: CMP R1,R1 then BZ 0x20 -> next imem_addr=0x20; CMP 1,2 then BZ -> pc+1 and flag_c=1.
- Wrap/halt/restart: PC_W=4, NOPs from pc=15 -> next fetch at 0; HLT -> halted=1, busy=0; run -> fetch at 0, GPRs intact.
- Ignored inputs: ld_en and run asserted during EXEC -> no register change, no restart; imem_valid in DECODE ignored.
- Async reset mid-FETCH: drop rst with imem_req=1 -> imem_req=0 the same cycle, pc=0, flags 0, no wb_en; with CPU_MUL_EN, MUL 0x10*0x10 -> wb_data=0x00, flag_c=1.
